parity_serial_tx: RTL and testbench

PARITY_SERIAL_TX -- requirements
Module: parity_serial_tx

---
 rtl/parity_pkg.sv | 15 +
 rtl/parity_gen.sv | 11 +
 rtl/parity_serial_tx.sv | 116 +++++++++++
 tb/tb_parity_serial_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and constants for the parity serial transmitter.
package parity_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Start, parity and stop bits wrapped around the data bits.
    localparam int FRAME_OVH = 3;

endpackage

// File: rtl/parity_gen.sv
// Even-parity generator: XOR reduction of the data word.
module parity_gen #(
    parameter int DATA_W = 3
) (
    input  logic [DATA_W-1:0] data,
    output logic              par
);

    assign par = ^data;

endmodule

// File: rtl/parity_serial_tx.sv
// Serial transmitter framing each word as start, data LSB first, even parity, stop.
// Optional build macro ERR_INJECT_EN adds inj_err to invert the parity bit of a frame.
module parity_serial_tx
    import parity_pkg::*;
#(
    parameter int DATA_W  = 3,
    parameter int BIT_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
`ifdef ERR_INJECT_EN
    input  logic              inj_err,
`endif
    output logic              din_ready,
    output logic              sout,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    tx_state_t         state, state_d;
    logic [CW-1:0]     bit_cnt, bit_cnt_d;
    logic [IW-1:0]     bit_idx, bit_idx_d;
    logic [DATA_W-1:0] data_q;
    logic              sout_q, sout_d;
    logic              par;
    logic              tx_par;
    logic              accept;
    logic              bit_end;

    parity_gen #(.DATA_W(DATA_W)) u_parity_gen (
        .data (data_q),
        .par  (par)
    );

`ifdef ERR_INJECT_EN
    logic inj_q;
    assign tx_par = par ^ inj_q;
`else
    assign tx_par = par;
`endif

    assign din_ready  = (state == IDLE) && !rst;
    assign busy       = (state != IDLE) && !rst;
    assign frame_done = (state == STOP) && bit_end && !rst;
    assign sout       = sout_q;
    assign accept     = din_valid && din_ready;
    assign bit_end    = (bit_cnt == CNT_LAST);

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_end ? '0 : bit_cnt + 1'b1;
        bit_idx_d = bit_idx;
        sout_d    = 1'b1;
        case (state)
            IDLE: begin
                bit_cnt_d = '0;
                if (accept) state_d = START;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_LAST) state_d = PARITY;
                    else                     bit_idx_d = bit_idx + 1'b1;
                end
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP:   if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The line value is chosen for the state being entered so sout can be a register.
        case (state_d)
            START:   sout_d = 1'b0;
            DATA:    sout_d = data_q[bit_idx_d];
            PARITY:  sout_d = tx_par;
            default: sout_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            data_q  <= '0;
            sout_q  <= 1'b1;
`ifdef ERR_INJECT_EN
            inj_q   <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            bit_idx <= bit_idx_d;
            sout_q  <= sout_d;
            if (accept) begin
                data_q <= din;
`ifdef ERR_INJECT_EN
                inj_q  <= inj_err;
`endif
            end
        end
    end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Scoreboard bench for parity_serial_tx: default geometry plus a DATA_W=1, BIT_CYC=1 instance.
module tb_parity_serial_tx;
    import parity_pkg::*;

    localparam int DW   = 3;
    localparam int BC   = 4;
    localparam int FLEN = (DW + FRAME_OVH) * BC;

    typedef struct packed {
        logic sout;
        logic done;
        logic busy;
        logic ready;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          inj_err;
    logic          din_ready, sout, busy, frame_done;

    logic [0:0]    s_din;
    logic          s_valid;
    logic          s_ready, s_sout, s_busy, s_done;

    always #5 clk = ~clk;

    parity_serial_tx #(.DATA_W(DW), .BIT_CYC(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
`ifdef ERR_INJECT_EN
        .inj_err    (inj_err),
`endif
        .din_ready  (din_ready),
        .sout       (sout),
        .busy       (busy),
        .frame_done (frame_done)
    );

    parity_serial_tx #(.DATA_W(1), .BIT_CYC(1)) dut_min (
        .clk        (clk),
        .rst        (rst),
        .din        (s_din),
        .din_valid  (s_valid),
`ifdef ERR_INJECT_EN
        .inj_err    (1'b0),
`endif
        .din_ready  (s_ready),
        .sout       (s_sout),
        .busy       (s_busy),
        .frame_done (s_done)
    );

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level in frame cycle k (1-based) for word w.
    function automatic logic frameBit(input logic [DW-1:0] w, input logic inj, input int k);
        int p;
        p = (k - 1) / BC;
        if (p == 0)      return 1'b0;
        if (p <= DW)     return w[p-1];
        if (p == DW + 1) return (^w) ^ inj;
        return 1'b1;
    endfunction

    task automatic checkIdle(input string tag);
        checkValue({tag, ".sout"},  32'(sout), 1);
        checkValue({tag, ".busy"},  32'(busy), 0);
        checkValue({tag, ".done"},  32'(frame_done), 0);
        checkValue({tag, ".ready"}, 32'(din_ready), 1);
    endtask

    task automatic applyStimulus(input logic [DW-1:0] w, input logic inj);
        exp_t e;
        checkValue("ready_at_accept", 32'(din_ready), 1);
        din       = w;
        din_valid = 1'b1;
        inj_err   = inj;
        for (int k = 1; k <= FLEN; k++) begin
            e.sout  = frameBit(w, inj, k);
            e.done  = (k == FLEN);
            e.busy  = 1'b1;
            e.ready = 1'b0;
            sb.push_back(e);
        end
    endtask

    // mode 1: scramble inputs during the frame; mode 0: keep valid high and present nextw.
    task automatic checkOutput(input int n, input bit mode, input logic [DW-1:0] nextw);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                checkValue("scoreboard_underflow", 0, 1);
            end else begin
                e = sb.pop_front();
                checkValue($sformatf("sout@%0d", i + 1),  32'(sout), 32'(e.sout));
                checkValue($sformatf("done@%0d", i + 1),  32'(frame_done), 32'(e.done));
                checkValue($sformatf("busy@%0d", i + 1),  32'(busy), 32'(e.busy));
                checkValue($sformatf("ready@%0d", i + 1), 32'(din_ready), 32'(e.ready));
            end
            if (mode) begin
                din       = DW'($urandom);
                inj_err   = 1'($urandom);
                din_valid = (i == n - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            end else begin
                din = nextw;
            end
        end
    endtask

    initial begin
        logic [3:0] min_pat;
        min_pat   = 4'b0111;
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        inj_err   = 1'b0;
        s_din     = 1'b0;
        s_valid   = 1'b0;

        repeat (3) @(negedge clk);
        checkValue("rst.sout",  32'(sout), 1);
        checkValue("rst.busy",  32'(busy), 0);
        checkValue("rst.done",  32'(frame_done), 0);
        checkValue("rst.ready", 32'(din_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        checkIdle("post_rst");

        $display("[TB] frame 011");
        applyStimulus(3'b011, 1'b0);
        checkOutput(FLEN, 1'b1, '0);
        @(negedge clk);
        checkIdle("idle_after_011");

        $display("[TB] frames 111 and 000");
        applyStimulus(3'b111, 1'b0);
        checkOutput(FLEN, 1'b1, '0);
        @(negedge clk);
        checkIdle("idle_after_111");
        applyStimulus(3'b000, 1'b0);
        checkOutput(FLEN, 1'b1, '0);
        @(negedge clk);
        checkIdle("idle_after_000");

        $display("[TB] back-to-back 001 then 100 with valid held");
        applyStimulus(3'b001, 1'b0);
        checkOutput(FLEN, 1'b0, 3'b100);
        @(negedge clk);
        checkIdle("gap_cycle");
        applyStimulus(3'b100, 1'b0);
        checkOutput(FLEN, 1'b1, '0);
        @(negedge clk);
        checkIdle("idle_after_b2b");

        $display("[TB] reset in cycle 10 of a frame");
        applyStimulus(3'b101, 1'b0);
        checkOutput(10, 1'b1, '0);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        checkValue("abort.sout",  32'(sout), 1);
        checkValue("abort.busy",  32'(busy), 0);
        checkValue("abort.done",  32'(frame_done), 0);
        checkValue("abort.ready", 32'(din_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        checkIdle("after_abort");
        applyStimulus(3'b110, 1'b0);
        checkOutput(FLEN, 1'b1, '0);
        @(negedge clk);
        checkIdle("idle_after_110");

`ifdef ERR_INJECT_EN
        $display("[TB] parity error injection");
        applyStimulus(3'b011, 1'b1);
        checkOutput(FLEN, 1'b1, '0);
        @(negedge clk);
        checkIdle("idle_after_inj");
        inj_err = 1'b0;
        applyStimulus(3'b011, 1'b0);
        checkOutput(FLEN, 1'b1, '0);
        @(negedge clk);
        checkIdle("idle_after_noinj");
`endif

        $display("[TB] DATA_W=1 BIT_CYC=1 instance");
        checkValue("min.ready_at_accept", 32'(s_ready), 1);
        s_din   = 1'b1;
        s_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            s_valid = 1'b0;
            checkValue($sformatf("min.sout@%0d", k),  32'(s_sout), 32'(min_pat[4-k]));
            checkValue($sformatf("min.done@%0d", k),  32'(s_done), (k == 4) ? 1 : 0);
            checkValue($sformatf("min.busy@%0d", k),  32'(s_busy), 1);
            checkValue($sformatf("min.ready@%0d", k), 32'(s_ready), 0);
        end
        @(negedge clk);
        checkValue("min.idle.sout",  32'(s_sout), 1);
        checkValue("min.idle.busy",  32'(s_busy), 0);
        checkValue("min.idle.ready", 32'(s_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
